layer_sequencer: RTL and testbench

Controller that sequences the per-node input accumulation of the neural-network datapath across every node of every configured layer. It holds a small layer configuration table, requests coefficient loads, drives the input node timer's `max_input`/`coef_ready` pair, waits for its `n_start_done` pulse, then triggers activation and result write-back before moving to the next node and layer. It sits between the top-level run control and the node timer / MAC datapath.

---
 rtl/layer_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_layer_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Sequences coefficient load, input accumulation, activation and write-back
// for every node of every configured layer, driven by a small config table.
module layer_sequencer #(
  parameter int MAX_LAYERS = 4,
  parameter int CNT_BITS   = 7
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          cfg_we,
  input  logic [$clog2(MAX_LAYERS)-1:0] cfg_addr,
  input  logic [CNT_BITS-1:0]           cfg_inputs,
  input  logic [CNT_BITS-1:0]           cfg_nodes,
  input  logic [$clog2(MAX_LAYERS):0]   num_layers,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          coef_ack,
  input  logic                          n_start_done,
  output logic                          coef_req,
  output logic                          coef_ready,
  output logic [CNT_BITS-1:0]           max_input,
  output logic                          act_en,
  output logic                          node_wr,
  output logic [$clog2(MAX_LAYERS)-1:0] layer_idx,
  output logic [CNT_BITS-1:0]           node_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          cfg_err
);

  localparam int LW = $clog2(MAX_LAYERS);

  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, ACT, WRITE, DONE} state_t;
  // Layer index with one extra bit so "one past the last layer" is representable.
  typedef logic [LW:0] ext_t;

  logic [CNT_BITS-1:0] inputs_mem [MAX_LAYERS];
  logic [CNT_BITS-1:0] nodes_mem  [MAX_LAYERS];
  logic [MAX_LAYERS-1:0] nz_mask;

  state_t              state_reg, state_next;
  ext_t                layers_reg, layers_next;
  logic [LW-1:0]       layer_reg, layer_next;
  logic [CNT_BITS-1:0] node_reg, node_next;
  logic [CNT_BITS-1:0] max_input_reg, max_input_next;
  logic                coef_req_reg, coef_ready_reg, act_en_reg, node_wr_reg;
  logic                busy_reg, done_reg, cfg_err_reg;

  ext_t                start_layers, first_layer, following_layer;
  logic [CNT_BITS:0]   node_inc;
  logic                last_node;

  // Table lives in flops: it needs a defined reset value for the skip logic.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        inputs_mem[i] <= CNT_BITS'(1);
        nodes_mem[i]  <= '0;
      end
    end else if (cfg_we && state_reg == IDLE) begin
      inputs_mem[cfg_addr] <= (cfg_inputs == '0) ? CNT_BITS'(1) : cfg_inputs;
      nodes_mem[cfg_addr]  <= cfg_nodes;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LAYERS; gi++) begin : g_nz
      assign nz_mask[gi] = (nodes_mem[gi] != '0);
    end
  endgenerate

  // First layer in [from, limit) that has nodes; returns limit when none does.
  function automatic ext_t find_layer(input ext_t from, input ext_t limit,
                                      input logic [MAX_LAYERS-1:0] mask);
    ext_t r;
    r = limit;
    for (int j = MAX_LAYERS - 1; j >= 0; j--) begin
      if (ext_t'(j) >= from && ext_t'(j) < limit && mask[j]) r = ext_t'(j);
    end
    return r;
  endfunction

  always_comb begin
    state_next      = state_reg;
    layers_next     = layers_reg;
    layer_next      = layer_reg;
    node_next       = node_reg;

    if (num_layers == '0)                      start_layers = ext_t'(1);
    else if (num_layers > ext_t'(MAX_LAYERS))  start_layers = ext_t'(MAX_LAYERS);
    else                                       start_layers = num_layers;

    first_layer     = find_layer('0, start_layers, nz_mask);
    following_layer = find_layer(ext_t'(layer_reg) + ext_t'(1), layers_reg, nz_mask);
    node_inc        = {1'b0, node_reg} + (CNT_BITS + 1)'(1);
    last_node       = node_inc >= {1'b0, nodes_mem[layer_reg]};

    case (state_reg)
      IDLE: begin
        if (start) begin
          layers_next = start_layers;
          layer_next  = '0;
          node_next   = '0;
          if (first_layer < start_layers) begin
            layer_next = first_layer[LW-1:0];
            state_next = LOAD;
          end else begin
            state_next = DONE;
          end
        end
      end
      LOAD:  if (coef_ack) state_next = ACCUM;
      ACCUM: if (n_start_done) state_next = ACT;
      ACT:   state_next = WRITE;
      WRITE: begin
        if (!last_node) begin
          node_next  = node_inc[CNT_BITS-1:0];
          state_next = LOAD;
        end else if (following_layer < layers_reg) begin
          layer_next = following_layer[LW-1:0];
          node_next  = '0;
          state_next = LOAD;
        end else begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (abort && state_reg != IDLE) begin
      state_next  = IDLE;
      layers_next = layers_reg;
      layer_next  = layer_reg;
      node_next   = node_reg;
    end

    max_input_next = (state_next != IDLE) ? inputs_mem[layer_next] : max_input_reg;
  end

  // Outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_reg      <= IDLE;
      layers_reg     <= ext_t'(1);
      layer_reg      <= '0;
      node_reg       <= '0;
      max_input_reg  <= '0;
      coef_req_reg   <= 1'b0;
      coef_ready_reg <= 1'b0;
      act_en_reg     <= 1'b0;
      node_wr_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      cfg_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      layers_reg     <= layers_next;
      layer_reg      <= layer_next;
      node_reg       <= node_next;
      max_input_reg  <= max_input_next;
      coef_req_reg   <= (state_next == LOAD);
      coef_ready_reg <= (state_next == ACCUM);
      act_en_reg     <= (state_next == ACT);
      node_wr_reg    <= (state_next == WRITE);
      busy_reg       <= (state_next != IDLE);
      done_reg       <= (state_next == DONE);
      cfg_err_reg    <= cfg_we && (state_reg != IDLE);
    end
  end

  assign coef_req   = coef_req_reg;
  assign coef_ready = coef_ready_reg;
  assign max_input  = max_input_reg;
  assign act_en     = act_en_reg;
  assign node_wr    = node_wr_reg;
  assign layer_idx  = layer_reg;
  assign node_idx   = node_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign cfg_err    = cfg_err_reg;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: a vector table of layer configurations
// with hand-computed totals, plus hand-written reset, abort and config-lock sequences.
module tb_layer_sequencer;

  logic       clk = 1'b0;
  logic       n_rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [6:0] cfg_inputs = '0;
  logic [6:0] cfg_nodes = '0;
  logic [2:0] num_layers = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       coef_ack = 1'b0;
  logic       n_start_done = 1'b0;
  logic       coef_req, coef_ready, act_en, node_wr, busy, done, cfg_err;
  logic [6:0] max_input, node_idx;
  logic [1:0] layer_idx;

  layer_sequencer #(.MAX_LAYERS(4), .CNT_BITS(7)) dut (
    .clk(clk), .n_rst(n_rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_inputs(cfg_inputs), .cfg_nodes(cfg_nodes), .num_layers(num_layers),
    .start(start), .abort(abort), .coef_ack(coef_ack), .n_start_done(n_start_done),
    .coef_req(coef_req), .coef_ready(coef_ready), .max_input(max_input),
    .act_en(act_en), .node_wr(node_wr), .layer_idx(layer_idx), .node_idx(node_idx),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Monitor state, cleared through mon_clear
  logic mon_clear = 1'b0;
  int   busy_cnt, wr_cnt, act_cnt, done_cnt, req_cnt;
  int   first_max, last_l, last_n;
  logic seen_ready, req_prev;
  logic [8:0] wr_log[$];
  logic [6:0] req_max_log[$];
  int   ack_wait = 0;
  int   tcnt = 0;

  // Monitor plus coefficient-loader (ack after one wait cycle) and node-timer models.
  always @(negedge clk) begin
    if (mon_clear) begin
      busy_cnt = 0; wr_cnt = 0; act_cnt = 0; done_cnt = 0; req_cnt = 0;
      first_max = 0; last_l = 0; last_n = 0; seen_ready = 1'b0; req_prev = 1'b0;
      wr_log.delete();
      req_max_log.delete();
    end else begin
      if (busy) busy_cnt++;
      if (act_en) act_cnt++;
      if (done) done_cnt++;
      if (node_wr) begin
        wr_cnt++;
        last_l = int'(layer_idx);
        last_n = int'(node_idx);
        wr_log.push_back({layer_idx, node_idx});
      end
      if (coef_req && !req_prev) begin
        req_cnt++;
        req_max_log.push_back(max_input);
      end
      req_prev = coef_req;
      if (coef_ready && !seen_ready) begin
        seen_ready = 1'b1;
        first_max = int'(max_input);
      end
    end
    if (coef_req) begin
      coef_ack = (ack_wait == 1);
      ack_wait++;
    end else begin
      coef_ack = 1'b0;
      ack_wait = 0;
    end
    if (coef_ready) begin
      tcnt++;
      n_start_done = (tcnt == int'(max_input));
    end else begin
      tcnt = 0;
      n_start_done = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg_write(input int addr, input int ins, input int nds);
    cfg_we = 1'b1;
    cfg_addr = 2'(addr);
    cfg_inputs = 7'(ins);
    cfg_nodes = 7'(nds);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input int nl);
    num_layers = 3'(nl);
    mon_clear = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    mon_clear = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      tick();
      k++;
    end
    check("run_completes", (done_cnt > 0) ? 1 : 0, 1);
    tick();
    tick();
  endtask

  typedef struct {
    int nl;
    int i0, n0, i1, n1, i2, n2, i3, n3;
    int exp_busy, exp_wr, exp_req, exp_max, exp_ll, exp_ln;
  } vec_t;

  function automatic vec_t mk(int nl, int i0, int n0, int i1, int n1, int i2, int n2,
                              int i3, int n3, int eb, int ew, int er, int em, int el, int en);
    vec_t v;
    v.nl = nl; v.i0 = i0; v.n0 = n0; v.i1 = i1; v.n1 = n1;
    v.i2 = i2; v.n2 = n2; v.i3 = i3; v.n3 = n3;
    v.exp_busy = eb; v.exp_wr = ew; v.exp_req = er; v.exp_max = em;
    v.exp_ll = el; v.exp_ln = en;
    return v;
  endfunction

  vec_t vecs[8];
  logic [8:0] exp_order[5];

  initial begin
    // Busy cycles per node = LOAD(2) + inputs + ACT + WRITE, plus one DONE cycle.
    vecs[0] = mk(1, 4,2, 1,0, 1,0, 1,0, 17, 2, 2, 4, 0,1);
    vecs[1] = mk(2, 3,2, 5,3, 1,0, 1,0, 42, 5, 5, 3, 1,2);
    vecs[2] = mk(3, 2,1, 9,0, 3,2, 1,0, 21, 3, 3, 2, 2,1);
    vecs[3] = mk(0, 2,1, 2,1, 1,0, 1,0,  7, 1, 1, 2, 0,0);
    vecs[4] = mk(7, 1,1, 1,1, 1,1, 1,1, 21, 4, 4, 1, 3,0);
    vecs[5] = mk(1, 0,1, 1,0, 1,0, 1,0,  6, 1, 1, 1, 0,0);
    vecs[6] = mk(2, 3,0, 3,0, 1,0, 1,0,  1, 0, 0, 0, 0,0);
    vecs[7] = mk(2, 4,0, 2,2, 1,0, 1,0, 13, 2, 2, 2, 1,1);
    exp_order[0] = {2'd0, 7'd0};
    exp_order[1] = {2'd0, 7'd1};
    exp_order[2] = {2'd1, 7'd0};
    exp_order[3] = {2'd1, 7'd1};
    exp_order[4] = {2'd1, 7'd2};

    // Power-on reset
    mon_clear = 1'b1;
    n_rst = 1'b1;
    repeat (3) tick();
    n_rst = 1'b0;
    mon_clear = 1'b0;
    @(negedge clk);
    check("rst_strobes", {25'd0, coef_req, coef_ready, act_en, node_wr, busy, done, cfg_err}, 0);
    check("rst_idx", {layer_idx, node_idx}, 0);
    check("rst_max_input", max_input, 0);
    $display("reset: busy=%0d coef_req=%0d max_input=%0d", busy, coef_req, max_input);

    // Reset held two cycles mid-ACCUM, then the table must read as empty
    cfg_write(0, 4, 2);
    start_run(1);
    begin
      int k;
      k = 0;
      while (!coef_ready && k < 50) begin @(negedge clk); k++; end
      check("reach_accum", coef_ready, 1);
    end
    tick();
    n_rst = 1'b1;
    tick();
    tick();
    n_rst = 1'b0;
    @(negedge clk);
    check("midrst_strobes", {25'd0, coef_req, coef_ready, act_en, node_wr, busy, done, cfg_err}, 0);
    check("midrst_idx", {layer_idx, node_idx}, 0);
    check("midrst_max_input", max_input, 0);
    start_run(4);
    wait_done();
    check("midrst_busy_cycles", busy_cnt, 1);
    check("midrst_coef_req", req_cnt, 0);
    $display("reset mid-accum: post-reset run busy=%0d reqs=%0d", busy_cnt, req_cnt);

    // Table-driven runs
    for (int i = 0; i < 8; i++) begin
      cfg_write(0, vecs[i].i0, vecs[i].n0);
      cfg_write(1, vecs[i].i1, vecs[i].n1);
      cfg_write(2, vecs[i].i2, vecs[i].n2);
      cfg_write(3, vecs[i].i3, vecs[i].n3);
      start_run(vecs[i].nl);
      wait_done();
      check("busy_cycles", busy_cnt, vecs[i].exp_busy);
      check("node_wr_count", wr_cnt, vecs[i].exp_wr);
      check("act_en_count", act_cnt, vecs[i].exp_wr);
      check("coef_req_count", req_cnt, vecs[i].exp_req);
      check("done_count", done_cnt, 1);
      check("first_max_input", first_max, vecs[i].exp_max);
      check("last_layer", last_l, vecs[i].exp_ll);
      check("last_node", last_n, vecs[i].exp_ln);
      $display("vec %0d: nl=%0d busy=%0d wr=%0d req=%0d max=%0d last=(%0d,%0d)",
               i, vecs[i].nl, busy_cnt, wr_cnt, req_cnt, first_max, last_l, last_n);
      if (i == 1) begin
        check("order_len", wr_log.size(), 5);
        for (int k = 0; k < 5; k++)
          if (k < wr_log.size()) check("order_entry", wr_log[k], exp_order[k]);
        if (req_max_log.size() == 5) begin
          check("max_layer0_last", req_max_log[1], 3);
          check("max_layer1_first", req_max_log[2], 5);
        end else begin
          check("req_log_len", req_max_log.size(), 5);
        end
      end
    end

    // Abort during ACCUM of the second node
    cfg_write(0, 4, 2);
    start_run(1);
    begin
      int k;
      k = 0;
      while (!(coef_ready && node_idx == 7'd1) && k < 100) begin @(negedge clk); k++; end
      check("abort_reach_node1", {24'd0, coef_ready, node_idx}, {24'd0, 1'b1, 7'd1});
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    check("abort_coef_ready", coef_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_node_hold", node_idx, 1);
    repeat (5) tick();
    check("abort_no_done", done_cnt, 0);
    $display("abort: coef_ready=%0d busy=%0d done_cnt=%0d", coef_ready, busy, done_cnt);
    start_run(1);
    @(negedge clk);
    check("restart_coef_req", {30'd0, coef_req, busy}, 3);
    check("restart_idx", {layer_idx, node_idx}, 0);
    wait_done();
    check("restart_wr_count", wr_cnt, 2);

    // Config writes while busy are rejected
    start_run(1);
    tick();
    cfg_we = 1'b1;
    cfg_addr = 2'd0;
    cfg_inputs = 7'd9;
    cfg_nodes = 7'd5;
    tick();
    cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_err_pulse", cfg_err, 1);
    @(negedge clk);
    check("cfg_err_clear", cfg_err, 0);
    wait_done();
    start_run(1);
    wait_done();
    check("locked_table_max", first_max, 4);
    check("locked_table_wr", wr_cnt, 2);
    $display("cfg while busy: rerun max=%0d wr=%0d", first_max, wr_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
